// File: rtl/mem2_pkg.sv
// mem2_pkg -- shared types for the second memory stage (mem2).
//
// Contents:
//   - ALU opcodes seen by mem2 (loads, LL/SC, stores)
//   - mem2_state_t     : load-response tracking FSM {IDLE, WAIT, HOLD, DROP}
//   - mem1_mem2_struct : registered result handed over by mem1
//   - mem2_wb_struct   : registered result handed to writeback
//   - mem2_data_forward_t : load-use forwarding bundle toward dispatch/EX
//
// Optional feature: `MEM2_DIFFTEST_EN adds debug_load_data to mem2_wb_struct.
package mem2_pkg;

    localparam int DATA_W = 32;

    // ALU opcodes relevant to the memory stages.
    localparam logic [7:0] ALUOP_NOP = 8'h00;
    localparam logic [7:0] LD_B      = 8'h10;
    localparam logic [7:0] LD_H      = 8'h11;
    localparam logic [7:0] LD_W      = 8'h12;
    localparam logic [7:0] LD_BU     = 8'h13;
    localparam logic [7:0] LD_HU     = 8'h14;
    localparam logic [7:0] LL        = 8'h15;
    localparam logic [7:0] ST_B      = 8'h18;
    localparam logic [7:0] ST_H      = 8'h19;
    localparam logic [7:0] ST_W      = 8'h1a;
    localparam logic [7:0] SC        = 8'h1b;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } mem2_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } instr_info_t;

    typedef struct packed {
        logic        we;
        logic [13:0] addr;
        logic [31:0] wdata;
    } csr_signal_t;

    typedef struct packed {
        logic       en;
        logic [4:0] op;
    } cacop_t;

    typedef struct packed {
        instr_info_t       instr_info;
        logic              wreg;
        logic [4:0]        waddr;
        logic [DATA_W-1:0] wdata;
        logic [31:0]       mem_addr;
        logic [7:0]        aluop;
        logic              excp;
        logic [15:0]       excp_num;
        logic              refetch;
        csr_signal_t       csr_signal;
        cacop_t            cacop;
        logic [4:0]        tlb_signal;
        logic [63:0]       timer_64;
        logic [7:0]        inst_ld_en;
        logic [7:0]        inst_st_en;
        logic [31:0]       load_addr;
        logic [31:0]       store_addr;
        logic [31:0]       store_data;
    } mem1_mem2_struct;

    typedef struct packed {
        instr_info_t       instr_info;
        logic              wreg;
        logic [4:0]        waddr;
        logic [DATA_W-1:0] wdata;
        logic              excp;
        logic [15:0]       excp_num;
        logic              refetch;
        csr_signal_t       csr_signal;
        logic [7:0]        aluop;
        cacop_t            cacop;
        logic [4:0]        tlb_signal;
        logic [63:0]       timer_64;
        logic [7:0]        inst_ld_en;
        logic [7:0]        inst_st_en;
        logic [31:0]       load_addr;
        logic [31:0]       store_addr;
        logic [31:0]       store_data;
`ifdef MEM2_DIFFTEST_EN
        logic [DATA_W-1:0] debug_load_data;
`endif
    } mem2_wb_struct;

    typedef struct packed {
        logic              wait_data;
        logic              wreg;
        logic [4:0]        waddr;
        logic [DATA_W-1:0] wdata;
    } mem2_data_forward_t;

    function automatic logic is_load_op(input logic [7:0] op);
        return (op == LD_B) || (op == LD_BU) || (op == LD_H) ||
               (op == LD_HU) || (op == LD_W) || (op == LL);
    endfunction

endpackage

// File: rtl/mem2_load_extract.sv
// mem2_load_extract -- combinational load data alignment and extension.
//
// Ports:
//   aluop  in  [7:0]            load opcode (non-load opcodes return word)
//   offset in  [1:0]            mem_addr[1:0] of the access
//   word   in  [DATA_WIDTH-1:0] aligned word read from the cache
//   result out [DATA_WIDTH-1:0] extracted, sign/zero-extended value
module mem2_load_extract
    import mem2_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W
) (
    input  logic [7:0]            aluop,
    input  logic [1:0]            offset,
    input  logic [DATA_WIDTH-1:0] word,
    output logic [DATA_WIDTH-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        result   = word;
        byte_sel = word[{offset, 3'b000} +: 8];
        // A half access with offset[0] set is misaligned; it is raised as ALE
        // upstream and never reaches here, but fall back to offset 0 anyway.
        half_sel = offset[0] ? word[15:0] : word[{offset[1], 4'b0000} +: 16];

        case (aluop)
            LD_B:    result = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            LD_BU:   result = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            LD_H:    result = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            LD_HU:   result = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem2.sv
// mem2 -- second memory stage: waits for the data cache read response of
// loads, extracts the addressed byte/half/word and registers the result
// toward writeback. Drives load-use forwarding and a global stall request.
//
// Ports:
//   clk                 in   pipeline clock
//   rst                 in   synchronous reset, active-high
//   stall               in   downstream hold; signal_o_buffer keeps its value
//   flush               in   pipeline flush; signal_o_buffer cleared
//   signal_i            in   mem1_mem2_struct, registered mem1 result
//   cache_data_ok       in   one-cycle pulse, cache_rdata valid this cycle
//   cache_rdata         in   aligned word read from the cache
//   signal_o_buffer     out  mem2_wb_struct, registered result to writeback
//   mem_data_forward_o  out  {wait_data, wreg, waddr, wdata} to dispatch/EX
//   stallreq            out  stall request while load data is outstanding
//
// Build option: define MEM2_DIFFTEST_EN to copy the difftest fields
// (inst_ld_en, inst_st_en, load_addr, store_addr, store_data) and the
// extracted load value (debug_load_data) into signal_o_buffer. Without it the
// difftest fields are zero and debug_load_data does not exist.
module mem2
    import mem2_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  mem1_mem2_struct       signal_i,
    input  logic                  cache_data_ok,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    output mem2_wb_struct         signal_o_buffer,
    output mem2_data_forward_t    mem_data_forward_o,
    output logic                  stallreq
);

    mem2_state_t           state;
    logic [DATA_WIDTH-1:0] rdata_buf;
    logic                  buf_valid;

    logic                  is_load;
    logic                  wait_cond;
    logic [DATA_WIDTH-1:0] load_word;
    logic [DATA_WIDTH-1:0] load_value;
    mem2_wb_struct         result;
    logic                  unused_bits;

    assign is_load = signal_i.instr_info.valid && !signal_i.excp &&
                     is_load_op(signal_i.aluop);

    // Load result not yet available this cycle.
    assign wait_cond = ((state == WAIT) && !cache_data_ok) ||
                       ((state == IDLE) && is_load && !cache_data_ok) ||
                       (state == DROP);

    // A buffered response (HOLD) takes precedence over the live cache bus.
    assign load_word = buf_valid ? rdata_buf : cache_rdata;

    mem2_load_extract #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_extract (
        .aluop (signal_i.aluop),
        .offset(signal_i.mem_addr[1:0]),
        .word  (load_word),
        .result(load_value)
    );

    always_comb begin
        result            = '0;
        result.instr_info = signal_i.instr_info;
        result.wreg       = signal_i.wreg && !signal_i.excp;
        result.waddr      = signal_i.waddr;
        result.wdata      = is_load ? load_value : signal_i.wdata;
        result.excp       = signal_i.excp;
        result.excp_num   = signal_i.excp_num;
        result.refetch    = signal_i.refetch;
        result.csr_signal = signal_i.csr_signal;
        result.aluop      = signal_i.aluop;
        result.cacop      = signal_i.cacop;
        result.tlb_signal = signal_i.tlb_signal;
        result.timer_64   = signal_i.timer_64;
`ifdef MEM2_DIFFTEST_EN
        result.inst_ld_en      = signal_i.inst_ld_en;
        result.inst_st_en      = signal_i.inst_st_en;
        result.load_addr       = signal_i.load_addr;
        result.store_addr      = signal_i.store_addr;
        result.store_data      = signal_i.store_data;
        result.debug_load_data = load_value;
`endif
    end

    always_comb begin
        mem_data_forward_o = '0;
        stallreq           = 1'b0;
        if (!rst) begin
            mem_data_forward_o.wait_data = wait_cond;
            mem_data_forward_o.wreg      = result.wreg;
            mem_data_forward_o.waddr     = result.waddr;
            mem_data_forward_o.wdata     = result.wdata;
            stallreq                     = wait_cond;
        end
    end

    // Upper address bits and (in the default build) the difftest inputs
    // are intentionally not consumed here.
    assign unused_bits = ^{signal_i.mem_addr[31:2], signal_i.inst_ld_en,
                           signal_i.inst_st_en, signal_i.load_addr,
                           signal_i.store_addr, signal_i.store_data};

    // NOTE: sequential state is written with non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            rdata_buf       <= '0;
            buf_valid       <= 1'b0;
            signal_o_buffer <= '0;
        end else begin
            // A load still waiting for data advances a bubble rather than
            // a half-formed result.
            if (flush) begin
                signal_o_buffer <= '0;
            end else if (!stall) begin
                signal_o_buffer <= wait_cond ? '0 : result;
            end

            unique case (state)
                IDLE: begin
                    if (flush) begin
                        buf_valid <= 1'b0;
                    end else if (is_load && !cache_data_ok) begin
                        state <= WAIT;
                    end else if (is_load && cache_data_ok && stall) begin
                        rdata_buf <= cache_rdata;
                        buf_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        // A response arriving with the flush is consumed and
                        // discarded; otherwise the next one is stale.
                        state <= cache_data_ok ? IDLE : DROP;
                    end else if (cache_data_ok) begin
                        rdata_buf <= cache_rdata;
                        if (stall) begin
                            buf_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (flush || !stall) begin
                        buf_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                DROP: begin
                    if (cache_data_ok) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem2.sv
// tb_mem2 -- directed, table-driven bench for mem2.
module tb_mem2;
    import mem2_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               stall;
    logic               flush;
    mem1_mem2_struct    signal_i;
    logic               cache_data_ok;
    logic [31:0]        cache_rdata;
    mem2_wb_struct      signal_o_buffer;
    mem2_data_forward_t mem_data_forward_o;
    logic               stallreq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem2 dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .flush             (flush),
        .signal_i          (signal_i),
        .cache_data_ok     (cache_data_ok),
        .cache_rdata       (cache_rdata),
        .signal_o_buffer   (signal_o_buffer),
        .mem_data_forward_o(mem_data_forward_o),
        .stallreq          (stallreq)
    );

    typedef struct {
        logic [7:0]  aluop;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic mem1_mem2_struct mk(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [4:0] wa);
        mem1_mem2_struct s;
        s                  = '0;
        s.instr_info.valid = 1'b1;
        s.instr_info.pc    = 32'h1c00_0000;
        s.aluop            = op;
        s.mem_addr         = addr;
        s.wreg             = 1'b1;
        s.waddr            = wa;
        s.timer_64         = 64'h0000_0000_0000_1234;
        return s;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi_cnt;
        mem1_mem2_struct s;

        vecs[0]  = '{LD_B,  32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80};
        vecs[1]  = '{LD_BU, 32'h0000_1003, 32'h80FF_1234, 32'h0000_0080};
        vecs[2]  = '{LD_B,  32'h0000_1000, 32'h80FF_1234, 32'h0000_0034};
        vecs[3]  = '{LD_B,  32'h0000_1002, 32'h80FF_1234, 32'hFFFF_FFFF};
        vecs[4]  = '{LD_H,  32'h0000_1002, 32'h80FF_1234, 32'hFFFF_80FF};
        vecs[5]  = '{LD_HU, 32'h0000_1002, 32'h80FF_1234, 32'h0000_80FF};
        vecs[6]  = '{LD_H,  32'h0000_1000, 32'h80FF_1234, 32'h0000_1234};
        vecs[7]  = '{LD_W,  32'h0000_1000, 32'h80FF_1234, 32'h80FF_1234};
        vecs[8]  = '{LL,    32'h0000_1000, 32'hCAFE_BABE, 32'hCAFE_BABE};
        vecs[9]  = '{LD_BU, 32'h0000_1001, 32'h0000_AB00, 32'h0000_00AB};
        vecs[10] = '{LD_H,  32'h0000_1001, 32'h1234_8765, 32'hFFFF_8765};
        vecs[11] = '{LD_HU, 32'h0000_1003, 32'h1234_8765, 32'h0000_8765};

        // Reset: outputs quiet even with a pending load on the input.
        rst           = 1'b1;
        stall         = 1'b0;
        flush         = 1'b0;
        cache_data_ok = 1'b0;
        cache_rdata   = 32'h0;
        signal_i      = mk(LD_W, 32'h0, 5'd1);
        tick();
        tick();
        #3;
        check("reset stallreq", 64'(stallreq), 64'(1'b0));
        check("reset wait_data", 64'(mem_data_forward_o.wait_data), 64'(1'b0));
        check("reset buf wdata", 64'(signal_o_buffer.wdata), 64'h0);
        check("reset buf valid", 64'(signal_o_buffer.instr_info.valid), 64'h0);
        rst = 1'b0;

        // Same-cycle data_ok extraction table.
        for (int i = 0; i < 12; i++) begin
            signal_i      = mk(vecs[i].aluop, vecs[i].addr, 5'(i + 1));
            cache_data_ok = 1'b1;
            cache_rdata   = vecs[i].rdata;
            #3;
            check($sformatf("vec%0d stallreq", i), 64'(stallreq), 64'(1'b0));
            check($sformatf("vec%0d fwd wdata", i), 64'(mem_data_forward_o.wdata), 64'(vecs[i].exp_wdata));
            tick();
            check($sformatf("vec%0d buf wdata", i), 64'(signal_o_buffer.wdata), 64'(vecs[i].exp_wdata));
            check($sformatf("vec%0d buf wreg", i), 64'(signal_o_buffer.wreg), 64'(1'b1));
            check($sformatf("vec%0d buf waddr", i), 64'(signal_o_buffer.waddr), 64'(i + 1));
        end

        // Late response: data_ok three cycles after issue.
        signal_i      = mk(LD_HU, 32'h0000_2002, 5'd7);
        cache_data_ok = 1'b0;
        cache_rdata   = 32'h0;
        hi_cnt        = 0;
        for (int c = 0; c < 3; c++) begin
            #3;
            if (stallreq) hi_cnt++;
            check("late wait_data", 64'(mem_data_forward_o.wait_data), 64'(1'b1));
            tick();
        end
        cache_data_ok = 1'b1;
        cache_rdata   = 32'hBEEF_0001;
        #3;
        check("late stallreq at ok", 64'(stallreq), 64'(1'b0));
        tick();
        check("late stall cycles", 64'(hi_cnt), 64'd3);
        check("late buf wdata", 64'(signal_o_buffer.wdata), 64'h0000_BEEF);

        // Response arriving under stall: HOLD, then release.
        signal_i      = mk(LD_W, 32'h0000_0100, 5'd9);
        cache_data_ok = 1'b0;
        #3;
        check("hold issue stallreq", 64'(stallreq), 64'(1'b1));
        tick();
        cache_data_ok = 1'b1;
        cache_rdata   = 32'h1234_5678;
        stall         = 1'b1;
        #3;
        check("hold ok stallreq", 64'(stallreq), 64'(1'b0));
        tick();
        cache_data_ok = 1'b0;
        cache_rdata   = 32'h0;
        #3;
        check("hold state", 64'(dut.state), 64'(HOLD));
        check("hold stallreq", 64'(stallreq), 64'(1'b0));
        check("hold buf held", 64'(signal_o_buffer.wdata), 64'h0);
        tick();
        stall = 1'b0;
        #3;
        check("hold release fwd", 64'(mem_data_forward_o.wdata), 64'h1234_5678);
        tick();
        check("hold buf wdata", 64'(signal_o_buffer.wdata), 64'h1234_5678);
        check("hold back to idle", 64'(dut.state), 64'(IDLE));

        // Flush while waiting, stale response dropped, then a fresh load.
        signal_i = mk(LD_W, 32'h0000_0200, 5'd10);
        tick();
        flush = 1'b1;
        #3;
        check("flush wait stallreq", 64'(stallreq), 64'(1'b1));
        tick();
        flush    = 1'b0;
        signal_i = '0;
        check("flush buf zero", 64'(signal_o_buffer.wdata), 64'h0);
        check("flush state drop", 64'(dut.state), 64'(DROP));
        #3;
        check("drop stallreq", 64'(stallreq), 64'(1'b1));
        tick();
        cache_data_ok = 1'b1;
        cache_rdata   = 32'hDEAD_BEEF;
        #3;
        check("drop stale wait_data", 64'(mem_data_forward_o.wait_data), 64'(1'b1));
        tick();
        check("drop buf zero", 64'(signal_o_buffer.wdata), 64'h0);
        check("drop to idle", 64'(dut.state), 64'(IDLE));
        signal_i      = mk(LD_BU, 32'h0000_0201, 5'd11);
        cache_data_ok = 1'b1;
        cache_rdata   = 32'h0000_AB00;
        #3;
        check("post-drop stallreq", 64'(stallreq), 64'(1'b0));
        tick();
        check("post-drop wdata", 64'(signal_o_buffer.wdata), 64'h0000_00AB);

        // Excepting load and SC never wait.
        s             = mk(LD_W, 32'h0000_0300, 5'd12);
        s.excp        = 1'b1;
        s.excp_num    = 16'h0040;
        signal_i      = s;
        cache_data_ok = 1'b0;
        #3;
        check("excp stallreq", 64'(stallreq), 64'(1'b0));
        tick();
        check("excp wreg", 64'(signal_o_buffer.wreg), 64'(1'b0));
        check("excp flag", 64'(signal_o_buffer.excp), 64'(1'b1));
        check("excp num", 64'(signal_o_buffer.excp_num), 64'h0040);
        s        = mk(SC, 32'h0000_0304, 5'd13);
        s.wdata  = 32'h1;
        signal_i = s;
        #3;
        check("sc stallreq", 64'(stallreq), 64'(1'b0));
        tick();
        check("sc wdata", 64'(signal_o_buffer.wdata), 64'h1);
        check("sc wreg", 64'(signal_o_buffer.wreg), 64'(1'b1));

        // Reset while waiting.
        signal_i = mk(LD_W, 32'h0000_0400, 5'd14);
        tick();
        rst = 1'b1;
        #3;
        check("rst-wait stallreq", 64'(stallreq), 64'(1'b0));
        check("rst-wait fwd wdata", 64'(mem_data_forward_o.wdata), 64'h0);
        tick();
        check("rst-wait state", 64'(dut.state), 64'(IDLE));
        check("rst-wait buf valid", 64'(signal_o_buffer.instr_info.valid), 64'h0);
        check("rst-wait buf wdata", 64'(signal_o_buffer.wdata), 64'h0);
        rst      = 1'b0;
        signal_i = '0;
        #3;
        check("after rst stallreq", 64'(stallreq), 64'(1'b0));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
